// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register file write-port arbiter: pipeline writeback plus queued MDU results
// Optional WB_BYPASS_EN: an MDU result skips the queue when the port and queue are idle.
module wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_we,
    input  logic [ADDRESS_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]       alu_wd,
    input  logic                        mdu_valid,
    output logic                        mdu_ready,
    input  logic [ADDRESS_WIDTH-1:0]    mdu_rd,
    input  logic [DATA_WIDTH-1:0]       mdu_wd,
    output logic [ADDRESS_WIDTH-1:0]    AD3,
    output logic [DATA_WIDTH-1:0]       WD3,
    output logic                        WE3,
    output logic [2**ADDRESS_WIDTH-1:0] busy_mask,
    output logic                        stall_req,
    output logic                        err_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDRESS_WIDTH-1:0] fifo_rd [DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_wd [DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         slot;
    logic [CNT_W-1:0]         count;
    logic [STV_W-1:0]         starve_cnt;

    logic fifo_empty;
    logic alu_write;
    logic mdu_xfer;
    logic bypass;
    logic push;
    logic pop;

    assign fifo_empty = (count == '0);
    assign mdu_ready  = rst_n && (count < CNT_W'(DEPTH));
    assign stall_req  = (starve_cnt == STV_W'(STARVE_LIMIT));
    assign alu_write  = alu_we && (alu_rd != '0);
    assign mdu_xfer   = mdu_valid && mdu_ready;

`ifdef WB_BYPASS_EN
    assign bypass = mdu_xfer && fifo_empty && !alu_write && !stall_req;
`else
    assign bypass = 1'b0;
`endif

    // stall_req only rises with a non-empty queue, so a stall always has a head to pop
    assign pop  = stall_req || (!alu_write && !fifo_empty);
    assign push = mdu_xfer && (mdu_rd != '0) && !bypass;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr] <= mdu_rd;
            fifo_wd[wr_ptr] <= mdu_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            err_drop   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (fifo_empty || pop)
                starve_cnt <= '0;
            else if (!stall_req)
                starve_cnt <= starve_cnt + 1'b1;
            if (alu_write && stall_req)
                err_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AD3 <= '0;
            WD3 <= '0;
            WE3 <= 1'b0;
        end else if (pop) begin
            AD3 <= fifo_rd[rd_ptr];
            WD3 <= fifo_wd[rd_ptr];
            WE3 <= 1'b1;
        end else if (alu_write) begin
            AD3 <= alu_rd;
            WD3 <= alu_wd;
            WE3 <= 1'b1;
        end else if (bypass && (mdu_rd != '0)) begin
            AD3 <= mdu_rd;
            WD3 <= mdu_wd;
            WE3 <= 1'b1;
        end else begin
            WE3 <= 1'b0;
        end
    end

    // Walk the occupied slots starting at the head; entries leave as soon as they are popped
    always_comb begin
        busy_mask = '0;
        slot      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < count)
                busy_mask[fifo_rd[slot]] = 1'b1;
        end
        busy_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized and directed bench for wb_arbiter against a queue-based model
module tb_wb_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_wd;
    logic [4:0]  AD3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] busy_mask;
    logic        stall_req;
    logic        err_drop;

    wb_arbiter #(
        .ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_wd(mdu_wd),
        .AD3(AD3), .WD3(WD3), .WE3(WE3),
        .busy_mask(busy_mask), .stall_req(stall_req), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    ent_t        q[$];
    int          starve;
    bit          exp_we;
    logic [4:0]  exp_ad;
    logic [31:0] exp_wd;
    bit          exp_err;

    logic        obs_ready = 1'b1;
    logic        obs_stall = 1'b0;
    logic [31:0] obs_mask  = '0;
    int          stall_at;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; alu_we = 1'b0; alu_rd = '0; alu_wd = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_wd = '0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_WE3", WE3, 0);
        check("rst_AD3", AD3, 0);
        check("rst_WD3", WD3, 0);
        check("rst_busy_mask", busy_mask, 0);
        check("rst_mdu_ready", mdu_ready, 0);
        check("rst_stall_req", stall_req, 0);
        check("rst_err_drop", err_drop, 0);
        q.delete(); starve = 0; exp_err = 0; exp_we = 0;
        obs_ready = 1'b1;
        rst_n = 1'b1;
    endtask

    // One clock: inputs were driven just after the previous edge.
    task automatic cycle();
        bit          m_ready, m_stall, alu_w, xfer, byp, popped, was_empty;
        logic [31:0] m_mask;
        ent_t        head;
        #3;
        m_ready = (q.size() < DEPTH);
        m_stall = (starve == STARVE_LIMIT);
        m_mask  = '0;
        foreach (q[i]) m_mask[q[i].rd] = 1'b1;
        m_mask[0] = 1'b0;
        obs_ready = mdu_ready; obs_stall = stall_req; obs_mask = busy_mask;
        check("mdu_ready", mdu_ready, m_ready);
        check("stall_req", stall_req, m_stall);
        check("busy_mask", busy_mask, m_mask);

        alu_w = alu_we && (alu_rd != 0);
        xfer  = mdu_valid && m_ready;
        byp   = 1'b0;
`ifdef WB_BYPASS_EN
        byp   = xfer && (q.size() == 0) && !alu_w && !m_stall;
`endif
        was_empty = (q.size() == 0);
        popped = 1'b0;
        exp_we = 1'b1;
        if (m_stall) begin
            head = q.pop_front(); popped = 1'b1;
            exp_ad = head.rd; exp_wd = head.wd;
            if (alu_w) exp_err = 1'b1;
        end else if (alu_w) begin
            exp_ad = alu_rd; exp_wd = alu_wd;
        end else if (!was_empty) begin
            head = q.pop_front(); popped = 1'b1;
            exp_ad = head.rd; exp_wd = head.wd;
        end else if (byp && mdu_rd != 0) begin
            exp_ad = mdu_rd; exp_wd = mdu_wd;
        end else begin
            exp_we = 1'b0;
        end
        if (popped || was_empty) starve = 0;
        else if (starve < STARVE_LIMIT) starve++;
        if (xfer && mdu_rd != 0 && !byp) q.push_back('{rd: mdu_rd, wd: mdu_wd});

        @(posedge clk); #1;
        check("WE3", WE3, exp_we);
        if (exp_we) begin
            check("AD3", AD3, exp_ad);
            check("WD3", WD3, exp_wd);
        end
        check("err_drop", err_drop, exp_err);
    endtask

    initial begin
        do_reset(3);
        cycle();
        check("ready_after_release", obs_ready, 1);

        alu_we = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
        cycle();
        check("pipe_AD3", AD3, 5);
        check("pipe_WD3", WD3, 32'hDEADBEEF);
        check("pipe_WE3", WE3, 1);
        alu_rd = 5'd0;
        cycle();
        check("pipe_x0_WE3", WE3, 0);

        // starvation and protocol violation: pipeline writes rd=3 every cycle
        do_reset(2);
        alu_we = 1'b1; alu_rd = 5'd3; alu_wd = 32'h0000A5A5;
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wd = 32'h12345678;
        cycle();
        mdu_valid = 1'b0;
        cycle();
        check("busy7_set", obs_mask[7], 1);
        stall_at = -1;
        for (int i = 2; i <= 20 && stall_at < 0; i++) begin
            cycle();
            if (obs_stall) stall_at = i;
        end
        alu_we = 1'b0;
        check("stall_cycle", stall_at, 9);
        check("starved_head_AD3", AD3, 7);
        check("starved_head_WD3", WD3, 32'h12345678);
        check("busy7_clear", busy_mask[7], 0);
        check("err_drop_set", err_drop, 1);
        cycle();
        check("stall_one_cycle", obs_stall, 0);
        repeat (3) cycle();
        check("err_drop_sticky", err_drop, 1);

        // FIFO full, pop, ready return
        do_reset(2);
        alu_we = 1'b1; alu_rd = 5'd2; alu_wd = 32'h22;
        for (int k = 0; k < DEPTH; k++) begin
            mdu_valid = 1'b1; mdu_rd = 5'(10 + k); mdu_wd = 32'(k + 100);
            cycle();
        end
        mdu_rd = 5'd14; mdu_wd = 32'd104;
        cycle();
        check("full_not_ready", obs_ready, 0);
        alu_we = 1'b0;
        cycle();
        check("full_pop_not_ready", obs_ready, 0);
        check("first_head_AD3", AD3, 10);
        cycle();
        check("ready_back", obs_ready, 1);
        mdu_valid = 1'b0;
        repeat (8) cycle();

        // bypass behaviour on an idle port
        do_reset(2);
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_wd = 32'h99;
        cycle();
        mdu_valid = 1'b0;
`ifdef WB_BYPASS_EN
        check("bypass_n1_WE3", WE3, 1);
        check("bypass_n1_AD3", AD3, 9);
        cycle();
        check("bypass_n2_WE3", WE3, 0);
`else
        check("nobypass_n1_WE3", WE3, 0);
        cycle();
        check("nobypass_n2_WE3", WE3, 1);
        check("nobypass_n2_AD3", AD3, 9);
`endif

        // randomized traffic
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            alu_we = ($urandom_range(0, 9) < 6) && (starve != STARVE_LIMIT);
            alu_rd = 5'($urandom_range(0, 31));
            alu_wd = $urandom;
            if (!(mdu_valid && !obs_ready)) begin
                mdu_valid = ($urandom_range(0, 2) == 0);
                mdu_rd    = 5'($urandom_range(0, 31));
                mdu_wd    = $urandom;
            end
            cycle();
        end

        // reset with entries queued: nothing may be written afterwards
        do_reset(1);
        alu_we = 1'b1; alu_rd = 5'd4; alu_wd = 32'h44;
        mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_wd = 32'h2020;
        cycle();
        mdu_rd = 5'd21;
        cycle();
        do_reset(2);
        repeat (5) cycle();
        check("post_reset_idle_WE3", WE3, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

- Write-side owner of the register file write port (AD3/WD3/WE3).
- Merges two writeback sources:
  - the in-order pipeline writeback (ALU/load results), which never stalls;
  - the long-latency multiply/divide unit (MDU), which uses a valid/ready handshake.
- MDU results wait in a small FIFO and drain into idle write-port cycles; a starvation timer can force a pipeline bubble.
- Also exports a pending-write mask so decode can hold instructions that read a register still queued here.

## Interface

Parameters:
- ADDRESS_WIDTH, 5: register index width.
- DATA_WIDTH, 32: register data width.
- DEPTH, 4: MDU FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8: cycles a FIFO head may wait before stall_req asserts; ≥1.

Ports:
- clk, in, 1: sole clock; all state on posedge.
- rst_n, in, 1: asynchronous, active-low reset.
- alu_we, in, 1: pipeline writeback request this cycle.
- alu_rd, in, ADDRESS_WIDTH: pipeline destination register.
- alu_wd, in, DATA_WIDTH: pipeline write data.
- mdu_valid, in, 1: MDU result offered.
- mdu_ready, out, 1: arbiter accepts the MDU result.
- mdu_rd, in, ADDRESS_WIDTH: MDU destination register.
- mdu_wd, in, DATA_WIDTH: MDU result.
- AD3, out, ADDRESS_WIDTH: register file write address, registered.
- WD3, out, DATA_WIDTH: register file write data, registered.
- WE3, out, 1: register file write enable, registered.
- busy_mask, out, 2**ADDRESS_WIDTH: bit r set while any queued MDU entry targets register r.
- stall_req, out, 1: pipeline must present no write next cycle.
- err_drop, out, 1: sticky flag; a pipeline write was lost.

## Operation

- **x0 handling:**
  - alu_we with alu_rd==0 is treated as idle.
  - An MDU transfer with mdu_rd==0 is accepted and discarded; it is not pushed.
  - busy_mask[0] is always 0.
- **MDU handshake:**
  - Transfer occurs on valid && ready.
  - mdu_ready = rst_n && (count < DEPTH). Ready depends on the registered count only, so a full FIFO is not ready even in a cycle where it pops.
  - The MDU must hold rd/wd stable while valid && !ready.
- **Grant per cycle, in priority order:**
  1. stall_req high → FIFO head.
  2. Pipeline write (alu_we, rd≠0) → pipeline.
  3. FIFO non-empty → head.
  4. Otherwise, write port idle (WE3←0).
- **Starvation:**
  - Counter clears when the FIFO is empty or the head pops.
  - Otherwise it increments, saturating at STARVE_LIMIT.
  - stall_req = (counter == STARVE_LIMIT).
- **Protocol violation:** a pipeline write (rd≠0) in a cycle where stall_req is high is dropped and sets err_drop until reset.
- **busy_mask:** combinational OR over valid FIFO entries. It clears in the cycle the head's write is presented on WE3.
- **FIFO:** circular buffer, wrap-around at DEPTH, count width $clog2(DEPTH+1). Push and pop in the same cycle leave count unchanged.

## Timing

- **Reset:** AD3=0, WD3=0, WE3=0, FIFO empty, counter=0, stall_req=0, err_drop=0, busy_mask=0, mdu_ready=0 while rst_n low.
- **Pipeline write:** presented at cycle n → WE3/AD3/WD3 at n+1.
- **MDU write:** accepted at n → enters FIFO at n+1 → earliest WE3 at n+2. busy_mask bit is set from n+1.
- **stall_req:** asserts after the head has waited STARVE_LIMIT cycles. The head is granted in that same cycle, so stall_req is high for exactly one cycle per starved entry.
- **Reset mid-operation:** queued entries are lost; no write is issued after rst_n deasserts until new requests arrive.

## Configuration

- **WB_BYPASS_EN defined:** an MDU transfer bypasses the FIFO and is written directly (WE3 at n+1) when all of these hold in the same cycle:
  - FIFO empty;
  - no pipeline write;
  - stall_req low.

  A bypassed entry never appears in busy_mask.
- **WB_BYPASS_EN undefined:** every MDU result passes through the FIFO; minimum MDU latency is 2 cycles.

## Test plan

- **Reset then idle:** rst_n low 3 cycles, release → WE3=0, mdu_ready=1 one cycle after release, busy_mask=0.
- **Pipeline only:** alu_we=1, rd=5, wd=0xDEADBEEF at n → AD3=5, WD3=0xDEADBEEF, WE3=1 at n+1. A write with rd=0 → WE3 stays 0.
- **MDU queued behind traffic:**
  - MDU pushes rd=7, wd=0x12345678 while the pipeline writes every cycle → busy_mask[7]=1.
  - With STARVE_LIMIT=8, stall_req pulses after 8 waiting cycles; the head is written the next cycle and busy_mask[7] clears.
- **FIFO full:** DEPTH=4 pushes with the pipeline busy → mdu_ready=0 on the 5th offer. One pop → ready returns the following cycle. Order of AD3 matches push order across wrap-around.
- **Violation:** pipeline write rd=3 during the stall_req cycle → no write to 3, err_drop=1 and held until reset.
- **Bypass, both builds:** idle port, MDU rd=9 at n → WE3 at n+1 with WB_BYPASS_EN, at n+2 without.
